// File: rtl/reg_dump_tx_pkg.sv
// Shared constants, state encoding and hex helper for the register dump transmitter.
package reg_dump_tx_pkg;

  localparam int unsigned FRAME_LEN = 6;

  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_NEXT_CHAR = 3'd3,
    ST_NEXT_REG  = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/reg_dump_tx_uart.sv
// 8N1 byte serializer, LSB first, idle high, every bit exactly DIV cycles.
module uart_tx_byte #(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int unsigned CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] EARLY     = CW'(DIV - 3);
  localparam logic [3:0]    STOP_BIT  = 4'd9;

  logic          active_q;
  logic [8:0]    shift_q;
  logic [3:0]    bit_q;
  logic [CW-1:0] baud_q;

  // ready rises two cycles before the stop bit ends so the caller's control
  // flow overlaps the tail of the stop bit; a new byte is only taken once idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      ready    <= 1'b1;
      txd      <= 1'b1;
      shift_q  <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
    end else if (!active_q) begin
      if (valid) begin
        active_q <= 1'b1;
        ready    <= 1'b0;
        txd      <= 1'b0;
        shift_q  <= {1'b1, data};
        bit_q    <= '0;
        baud_q   <= '0;
      end
    end else begin
      if (baud_q == BAUD_LAST) begin
        baud_q <= '0;
        if (bit_q == STOP_BIT) begin
          active_q <= 1'b0;
        end else begin
          bit_q   <= bit_q + 4'd1;
          txd     <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        baud_q <= baud_q + CW'(1);
      end
      if (bit_q == STOP_BIT && baud_q == EARLY) begin
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Walks register addresses 0..NREGS-1 and streams each as "i=HH\r\n" over UART.
module reg_dump_tx
  import reg_dump_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       DIV     = CLK_HZ / BAUD;
  localparam logic [2:0]        LAST_CI = 3'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_RA = ADDR_W'(NREGS - 1);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] ra_q, ra_n;
  logic [2:0]        ci_q, ci_n;
  logic [DATA_W-1:0] snap_q, snap_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              sent_q, sent_n;
  logic              tx_valid_c;
  logic              tx_ready;
  logic [7:0]        tx_byte_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      ci_q    <= '0;
      snap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ra_q    <= ra_n;
      ci_q    <= ci_n;
      snap_q  <= snap_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      sent_q  <= sent_n;
    end
  end

  // SEND offers the byte on its first cycle, then waits for the serializer.
  always_comb begin
    state_n    = state_q;
    ra_n       = ra_q;
    ci_n       = ci_q;
    snap_n     = snap_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
    sent_n     = sent_q;
    tx_valid_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_n  = 1'b1;
          ra_n    = '0;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        snap_n  = rd;
        ci_n    = '0;
        sent_n  = 1'b0;
        state_n = ST_SEND;
      end
      ST_SEND: begin
        if (!sent_q) begin
          tx_valid_c = 1'b1;
          sent_n     = 1'b1;
        end else if (tx_ready) begin
          state_n = (ci_q == LAST_CI) ? ST_NEXT_REG : ST_NEXT_CHAR;
        end
      end
      ST_NEXT_CHAR: begin
        ci_n    = ci_q + 3'd1;
        sent_n  = 1'b0;
        state_n = ST_SEND;
      end
      ST_NEXT_REG: begin
        if (ra_q == LAST_RA) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          ra_n    = '0;
          state_n = ST_FINISH;
        end else begin
          ra_n    = ra_q + ADDR_W'(1);
          state_n = ST_LOAD;
        end
      end
      ST_FINISH: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    unique case (ci_q)
      3'd0:    tx_byte_c = hex_ascii(4'(ra_q));
      3'd1:    tx_byte_c = ASCII_EQ;
      3'd2:    tx_byte_c = hex_ascii(snap_q[7:4]);
      3'd3:    tx_byte_c = hex_ascii(snap_q[3:0]);
      3'd4:    tx_byte_c = ASCII_CR;
      default: tx_byte_c = ASCII_LF;
    endcase
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .valid(tx_valid_c),
    .data (tx_byte_c),
    .ready(tx_ready),
    .txd  (txd)
  );

  assign ra   = ra_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
